// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: serial line in, byte/strobe/flags out.
interface uart_rx_if;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    // Receiver side: samples the line, drives the byte and status.
    modport master (
        input  i_rx,
        output o_data,
        output o_valid,
        output o_parity_err,
        output o_frame_err,
        output o_busy
    );

    // Line driver / byte consumer side.
    modport slave (
        output i_rx,
        input  o_data,
        input  o_valid,
        input  o_parity_err,
        input  o_frame_err,
        input  o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, 1 stop bit.
// Line is resynchronised, start edge qualified at mid-bit, then each bit
// sampled at its centre. Stop bit low parks the FSM until the line idles.
module uart_rx #(
    parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE        = 115200
) (
    input  logic     i_clk,
    input  logic     i_rst,
    uart_rx_if.master bus
);
    localparam int unsigned CYCLES_PER_BAUD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BAUD       = CYCLES_PER_BAUD / 2;
    localparam int unsigned CW              = $clog2(CYCLES_PER_BAUD);

    localparam logic [CW-1:0] CntHalf = CW'(HALF_BAUD - 1);
    localparam logic [CW-1:0] CntFull = CW'(CYCLES_PER_BAUD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e        state_q;
    logic          rx_meta_q;
    logic          rx_s_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          perr_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          parity_err_q;
    logic          frame_err_q;
    logic          busy_q;

    // Synchronizer, receive FSM, bit timing and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q <= bus.i_rx;
            rx_s_q    <= rx_meta_q;
            valid_q   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= StStart;
                        busy_q  <= 1'b1;
                    end
                end

                StStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StData: begin
                    if (cnt_q == CntFull) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StParity: begin
                    if (cnt_q == CntFull) begin
                        cnt_q   <= '0;
                        perr_q  <= rx_s_q ^ (^shift_q);
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StStop: begin
                    if (cnt_q == CntFull) begin
                        cnt_q        <= '0;
                        data_q       <= shift_q;
                        parity_err_q <= perr_q;
                        frame_err_q  <= ~rx_s_q;
                        valid_q      <= 1'b1;
                        if (rx_s_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            // Line held low: wait for idle so a break is not a new start.
                            state_q <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StBreak: begin
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_parity_err = parity_err_q;
    assign bus.o_frame_err  = frame_err_q;
    assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven serially, expected bytes/flags go into
// a scoreboard queue and are popped whenever the receiver strobes o_valid.
module tb_uart_rx;
    localparam int CPB  = 100;   // 100 MHz / 1 Mbaud keeps the run short
    localparam int HALF = CPB / 2;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int start_cyc  = 0;
    int valid_cyc  = 0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];

    uart_rx_if bus ();
    assign bus.i_rx = rx;

    uart_rx #(
        .INPUT_CLOCK_FREQ(100_000_000),
        .BAUD_RATE       (1_000_000)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic perr, input logic ferr);
        exp_t e;
        e.data = d;
        e.perr = perr;
        e.ferr = ferr;
        exp_q.push_back(e);
    endtask

    // Drives one frame; caller is at a negedge, returns at a negedge.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int bl);
        rx = 1'b0;
        repeat (bl) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bl) @(negedge clk);
        end
        rx = par;
        repeat (bl) @(negedge clk);
        rx = stop;
        repeat (bl) @(negedge clk);
    endtask

    // Scoreboard consumer: compares every strobe against the queue head.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.o_valid === 1'b1 && prev_valid === 1'b1)
                check_eq("valid_width", 2, 1);
            if (bus.o_valid === 1'b1 && prev_valid !== 1'b1) begin
                valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("data", {24'd0, bus.o_data}, {24'd0, e.data});
                    check_eq("parity_err", {31'd0, bus.o_parity_err}, {31'd0, e.perr});
                    check_eq("frame_err", {31'd0, bus.o_frame_err}, {31'd0, e.ferr});
                end
            end
        end
        prev_valid = bus.o_valid;
    end

    initial begin
        repeat (4) @(negedge clk);
        check_eq("rst_data", {24'd0, bus.o_data}, 0);
        check_eq("rst_valid", {31'd0, bus.o_valid}, 0);
        check_eq("rst_perr", {31'd0, bus.o_parity_err}, 0);
        check_eq("rst_ferr", {31'd0, bus.o_frame_err}, 0);
        check_eq("rst_busy", {31'd0, bus.o_busy}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: clean 0x55, plus start-edge to strobe latency
        push_exp(8'h55, 1'b0, 1'b0);
        start_cyc = cyc;
        send_frame(8'h55, 1'b0, 1'b1, CPB);
        repeat (5) @(negedge clk);
        check_eq("t1_latency_ok",
                 {31'd0, (valid_cyc - start_cyc >= 10 * CPB + HALF + 2) &&
                         (valid_cyc - start_cyc <= 10 * CPB + HALF + 5)}, 1);
        check_eq("t1_busy_after", {31'd0, bus.o_busy}, 0);
        check_eq("t1_pending", exp_q.size(), 0);

        // 2: 0xA7 with correct parity, then with wrong parity
        push_exp(8'hA7, 1'b0, 1'b0);
        send_frame(8'hA7, 1'b1, 1'b1, CPB);
        repeat (5) @(negedge clk);
        push_exp(8'hA7, 1'b1, 1'b0);
        send_frame(8'hA7, 1'b0, 1'b1, CPB);
        repeat (5) @(negedge clk);
        check_eq("t2_pending", exp_q.size(), 0);
        check_eq("t2_perr_held", {31'd0, bus.o_parity_err}, 1);

        // 3: stop bit low, line held low for 3 bit times total, then released
        push_exp(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, CPB);
        repeat (2 * CPB) @(negedge clk);
        check_eq("t3_busy_in_break", {31'd0, bus.o_busy}, 1);
        check_eq("t3_pending", exp_q.size(), 0);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t3_busy_released", {31'd0, bus.o_busy}, 0);
        check_eq("t3_ferr_held", {31'd0, bus.o_frame_err}, 1);
        repeat (2 * CPB) @(negedge clk);

        // 4: short low glitch, must be rejected at mid-bit
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        check_eq("t4_busy_during", {31'd0, bus.o_busy}, 1);
        repeat (HALF - 20 + 10) @(negedge clk);
        check_eq("t4_busy_after", {31'd0, bus.o_busy}, 0);
        repeat (2 * CPB) @(negedge clk);
        check_eq("t4_pending", exp_q.size(), 0);

        // 5: reset in the middle of data bit 3 of a 0xFF frame
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB + HALF) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_data", {24'd0, bus.o_data}, 0);
        check_eq("t5_valid", {31'd0, bus.o_valid}, 0);
        check_eq("t5_perr", {31'd0, bus.o_parity_err}, 0);
        check_eq("t5_ferr", {31'd0, bus.o_frame_err}, 0);
        check_eq("t5_busy", {31'd0, bus.o_busy}, 0);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check_eq("t5_no_valid", exp_q.size(), 0);
        push_exp(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, CPB);
        repeat (5) @(negedge clk);
        check_eq("t5_pending", exp_q.size(), 0);

        // 6: back-to-back frames at a slightly slow transmitter rate
        push_exp(8'h00, 1'b0, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1, CPB + 1);
        send_frame(8'hFF, 1'b0, 1'b1, CPB + 1);
        repeat (5) @(negedge clk);
        check_eq("t6_pending", exp_q.size(), 0);
        check_eq("t6_busy_after", {31'd0, bus.o_busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
